// File: rtl/button_debounce_if.sv
// Pin-side bundle of the push-button debouncer: raw pin in, clean level and event pulses out.
// Latency: n/a (signal bundle only).
// Backpressure: none; every signal is a plain level or single-cycle pulse.
//
// Signals:
//   button_        raw pin, asynchronous, active low (0 = pressed)
//   button_db_     debounced level, active low
//   press_pulse    1-cycle pulse on accepted press
//   release_pulse  1-cycle pulse on accepted release
//   long_press     1-cycle pulse when a press has been held long enough
//   long_held      level, high from long_press until the release is accepted
interface button_debounce_if;
  logic button_;
  logic button_db_;
  logic press_pulse;
  logic release_pulse;
  logic long_press;
  logic long_held;

  // Debouncer side: consumes the pin, produces the clean outputs.
  modport slave (
    input  button_,
    output button_db_,
    output press_pulse,
    output release_pulse,
    output long_press,
    output long_held
  );

  // Board/consumer side: drives the pin, observes the clean outputs.
  modport master (
    output button_,
    input  button_db_,
    input  press_pulse,
    input  release_pulse,
    input  long_press,
    input  long_held
  );
endinterface

// File: rtl/button_debounce.sv
// Debounces an active-low push button into a clean level plus press/release/long-press events.
// Latency: SYNC_STAGES-1+DEBOUNCE_CYCLES edges from first synchroniser capture to output change.
// Backpressure: none; events are single-cycle pulses and are never held off.
//
// Ports:
//   clk     system clock
//   reset_  synchronous reset, active low
//   bif     button_debounce_if.slave (button_ in; button_db_, press_pulse,
//           release_pulse, long_press, long_held out)
module button_debounce #(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter int LONG_PRESS_CYCLES = 25000000
) (
  input  logic             clk,
  input  logic             reset_,
  button_debounce_if.slave bif
);

  // db_cnt only ever reaches DEBOUNCE_CYCLES-1; hold_cnt must reach LONG_PRESS_CYCLES itself.
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_ONE   = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_HIT = HOLD_W'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser. Resets to 1 so the pin reads as released out of reset.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;

  always_ff @(posedge clk) begin
    if (!reset_) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bif.button_};
    end
  end

  assign btn_s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  state_t              state_q,     state_d;
  logic [DB_W-1:0]     db_cnt_q,    db_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q,  hold_cnt_d;
  logic                button_db_q, button_db_d;
  logic                press_q,     press_d;
  logic                release_q,   release_d;
  logic                long_q,      long_d;
  logic                held_q,      held_d;
  logic                hold_run;

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q     <= RELEASED;
      db_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      button_db_q <= 1'b1;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      held_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      button_db_q <= button_db_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      held_q      <= held_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    button_db_d = button_db_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    held_d      = held_q;
    hold_run    = 1'b0;

    case (state_q)
      RELEASED: begin
        if (!btn_s) begin
          state_d  = PRESS_PEND;
          db_cnt_d = DB_ONE;
        end
      end

      PRESS_PEND: begin
        if (btn_s) begin
          // Bounce back to released before the window closed: drop silently.
          state_d  = RELEASED;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = PRESSED;
          db_cnt_d    = '0;
          button_db_d = 1'b0;
          press_d     = 1'b1;
          hold_cnt_d  = '0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      PRESSED: begin
        hold_run = 1'b1;
        if (btn_s) begin
          state_d  = RELEASE_PEND;
          db_cnt_d = DB_ONE;
        end
      end

      RELEASE_PEND: begin
        if (!btn_s) begin
          // Release glitch: still the same press, so the hold time carries on.
          state_d  = PRESSED;
          db_cnt_d = '0;
          hold_run = 1'b1;
        end else if (db_cnt_q == DB_LAST) begin
          // Accepting the release suppresses a long press landing on this edge.
          state_d     = RELEASED;
          db_cnt_d    = '0;
          button_db_d = 1'b1;
          release_d   = 1'b1;
          held_d      = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
          hold_run = 1'b1;
        end
      end

      default: begin
        state_d  = RELEASED;
        db_cnt_d = '0;
      end
    endcase

    // Saturating hold counter; long_press fires only on the step into HOLD_MAX,
    // so it cannot re-fire while the same press continues.
    if (hold_run && (hold_cnt_q != HOLD_MAX)) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
      if (hold_cnt_q == HOLD_HIT) begin
        long_d = 1'b1;
        held_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs are straight from flops: no combinational path from the pin.
  // ---------------------------------------------------------------------------
  assign bif.button_db_    = button_db_q;
  assign bif.press_pulse   = press_q;
  assign bif.release_pulse = release_q;
  assign bif.long_press    = long_q;
  assign bif.long_held     = held_q;

`ifndef SYNTHESIS
  a_pulse_excl : assert property (@(posedge clk) disable iff (!reset_)
    !(press_q && release_q));
  a_long_implies_held : assert property (@(posedge clk) disable iff (!reset_)
    long_q |-> held_q);
  a_long_while_pressed : assert property (@(posedge clk) disable iff (!reset_)
    held_q |-> !button_db_q);
`endif

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;

  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int LP   = 10;

  logic clk = 1'b0;
  logic reset_;

  always #5 clk = ~clk;

  button_debounce_if bif ();

  button_debounce #(
    .SYNC_STAGES      (SYNC),
    .DEBOUNCE_CYCLES  (DB),
    .LONG_PRESS_CYCLES(LP)
  ) dut (
    .clk   (clk),
    .reset_(reset_),
    .bif   (bif)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: the synchroniser is a plain delay line; debounce is a
  // run-length count of samples that disagree with the accepted level; hold
  // time is the number of cycles elapsed since the press was accepted.
  logic [SYNC-1:0] m_sync;
  logic m_db, m_press, m_rel, m_long, m_held;
  int   m_run, m_hold;

  task automatic model_step(input logic b, input logic r);
    logic s;
    logic old_db;
    logic accept;
    m_press = 1'b0;
    m_rel   = 1'b0;
    m_long  = 1'b0;
    if (!r) begin
      m_sync = '1;
      m_db   = 1'b1;
      m_run  = 0;
      m_hold = 0;
      m_held = 1'b0;
    end else begin
      s      = m_sync[SYNC-1];
      m_sync = {m_sync[SYNC-2:0], b};
      old_db = m_db;
      accept = 1'b0;
      if (s != m_db) begin
        m_run++;
        if (m_run == DB) begin
          accept = 1'b1;
          m_run  = 0;
          m_db   = s;
        end
      end else begin
        m_run = 0;
      end
      if (accept && !m_db) begin
        m_press = 1'b1;
        m_hold  = 0;
      end else if (accept) begin
        m_rel  = 1'b1;
        m_held = 1'b0;
      end else if (!old_db && m_hold < LP) begin
        m_hold++;
        if (m_hold == LP) begin
          m_long = 1'b1;
          m_held = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [4:0] expv();
    return {m_db, m_press, m_rel, m_long, m_held};
  endfunction

  function automatic logic [4:0] obs();
    return {bif.button_db_, bif.press_pulse, bif.release_pulse, bif.long_press, bif.long_held};
  endfunction

  // Drive one cycle of pin/reset, advance one edge, sample on the falling edge.
  task automatic tick(input logic b, input logic r);
    bif.button_ = b;
    reset_      = r;
    @(posedge clk);
    model_step(b, r);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    checks++;
    if (obs() !== 5'b10000) begin
      errors++;
      $display("FAIL reset_state cyc=%0d got=%b exp=%b", cyc, obs(), 5'b10000);
    end
    for (int k = 0; k < 20; k++) begin
      tick(1'b1, 1'b1);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL reset_idle_model cyc=%0d got=%b exp=%b", cyc, obs(), expv());
      end
      checks++;
      if (obs() !== 5'b10000) begin
        errors++;
        $display("FAIL reset_idle_const cyc=%0d got=%b exp=%b", cyc, obs(), 5'b10000);
      end
    end
  endtask

  task automatic test_press_release();
    int first;
    int n;
    first = -1;
    n     = 0;
    for (int k = 1; k <= 8; k++) begin
      tick(1'b0, 1'b1);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL press_model cyc=%0d got=%b exp=%b", cyc, obs(), expv());
      end
      if (bif.press_pulse) begin
        n++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (first !== 6) begin
      errors++;
      $display("FAIL press_latency got=%0d exp=%0d", first, 6);
    end
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL press_pulse_width got=%0d exp=%0d", n, 1);
    end
    first = -1;
    n     = 0;
    for (int k = 1; k <= 10; k++) begin
      tick(1'b1, 1'b1);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL release_model cyc=%0d got=%b exp=%b", cyc, obs(), expv());
      end
      if (bif.release_pulse) begin
        n++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (first !== 6) begin
      errors++;
      $display("FAIL release_latency got=%0d exp=%0d", first, 6);
    end
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL release_pulse_width got=%0d exp=%0d", n, 1);
    end
    checks++;
    if (bif.button_db_ !== 1'b1) begin
      errors++;
      $display("FAIL release_level got=%b exp=%b", bif.button_db_, 1'b1);
    end
  endtask

  task automatic test_bounce();
    logic pat [0:16];
    for (int k = 0; k < 17; k++) pat[k] = 1'b1;
    for (int k = 0; k < 3; k++) pat[k] = 1'b0;
    for (int k = 4; k < 7; k++) pat[k] = 1'b0;
    for (int k = 0; k < 17; k++) begin
      tick(pat[k], 1'b1);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL bounce_model cyc=%0d got=%b exp=%b", cyc, obs(), expv());
      end
      checks++;
      if (obs() !== 5'b10000) begin
        errors++;
        $display("FAIL bounce_quiet cyc=%0d got=%b exp=%b", cyc, obs(), 5'b10000);
      end
    end
  endtask

  task automatic test_long_press();
    int p_at;
    int l_at;
    int n_long;
    logic prev_held;
    p_at   = -1;
    l_at   = -1;
    n_long = 0;
    for (int k = 1; k <= 30; k++) begin
      tick(1'b0, 1'b1);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL long_model cyc=%0d got=%b exp=%b", cyc, obs(), expv());
      end
      if (bif.press_pulse && p_at < 0) p_at = k;
      if (bif.long_press) begin
        n_long++;
        if (l_at < 0) l_at = k;
      end
    end
    checks++;
    if (l_at - p_at !== LP) begin
      errors++;
      $display("FAIL long_press_delay got=%0d exp=%0d", l_at - p_at, LP);
    end
    checks++;
    if (n_long !== 1) begin
      errors++;
      $display("FAIL long_press_once got=%0d exp=%0d", n_long, 1);
    end
    checks++;
    if (bif.long_held !== 1'b1) begin
      errors++;
      $display("FAIL long_held_level got=%b exp=%b", bif.long_held, 1'b1);
    end
    prev_held = bif.long_held;
    for (int k = 1; k <= 10; k++) begin
      tick(1'b1, 1'b1);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL long_release_model cyc=%0d got=%b exp=%b", cyc, obs(), expv());
      end
      if (bif.release_pulse) begin
        checks++;
        if ({prev_held, bif.long_held} !== 2'b10) begin
          errors++;
          $display("FAIL long_held_drop got=%b exp=%b", {prev_held, bif.long_held}, 2'b10);
        end
      end
      prev_held = bif.long_held;
    end
  endtask

  // Press released so that the long-press threshold lands on the release-accept edge.
  task automatic test_tie();
    int n_long;
    int n_held;
    int n_rel;
    n_long = 0;
    n_held = 0;
    n_rel  = 0;
    for (int k = 0; k < 20; k++) begin
      tick((k < 10) ? 1'b0 : 1'b1, 1'b1);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL tie_model cyc=%0d got=%b exp=%b", cyc, obs(), expv());
      end
      if (bif.long_press) n_long++;
      if (bif.long_held) n_held++;
      if (bif.release_pulse) n_rel++;
    end
    checks++;
    if ({n_long, n_held} !== {32'd0, 32'd0}) begin
      errors++;
      $display("FAIL tie_no_long got=%0d/%0d exp=0/0", n_long, n_held);
    end
    checks++;
    if (n_rel !== 1) begin
      errors++;
      $display("FAIL tie_release got=%0d exp=%0d", n_rel, 1);
    end
  endtask

  task automatic test_reset_mid();
    int first;
    for (int pass = 0; pass < 2; pass++) begin
      // pass 0: reset while PRESSED; pass 1: reset during PRESS_PEND.
      for (int k = 0; k < ((pass == 0) ? 8 : 3); k++) begin
        tick(1'b0, 1'b1);
        checks++;
        if (obs() !== expv()) begin
          errors++;
          $display("FAIL rstmid_pre_model cyc=%0d got=%b exp=%b", cyc, obs(), expv());
        end
      end
      tick(1'b0, 1'b0);
      checks++;
      if (obs() !== 5'b10000) begin
        errors++;
        $display("FAIL rstmid_state pass=%0d got=%b exp=%b", pass, obs(), 5'b10000);
      end
      first = -1;
      for (int k = 1; k <= 10; k++) begin
        tick(1'b0, 1'b1);
        checks++;
        if (obs() !== expv()) begin
          errors++;
          $display("FAIL rstmid_post_model cyc=%0d got=%b exp=%b", cyc, obs(), expv());
        end
        if (bif.press_pulse && first < 0) first = k;
      end
      checks++;
      if (first !== 6) begin
        errors++;
        $display("FAIL rstmid_repress pass=%0d got=%0d exp=%0d", pass, first, 6);
      end
      for (int k = 0; k < 10; k++) tick(1'b1, 1'b1);
    end
  endtask

  task automatic test_random();
    logic lvl;
    int   len;
    logic r;
    while (cyc < 1800) begin
      lvl = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       len = $urandom_range(1, 3);
        1:       len = $urandom_range(12, 24);
        default: len = $urandom_range(4, 9);
      endcase
      for (int k = 0; k < len; k++) begin
        r = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
        tick(lvl, r);
        checks++;
        if (obs() !== expv()) begin
          errors++;
          $display("FAIL random_model cyc=%0d got=%b exp=%b", cyc, obs(), expv());
        end
        if (bif.press_pulse && bif.release_pulse) begin
          errors++;
          $display("FAIL random_pulse_excl cyc=%0d got=11 exp=not both", cyc);
        end
      end
    end
  endtask

  initial begin
    reset_      = 1'b0;
    bif.button_ = 1'b1;
    test_reset();
    test_press_release();
    test_bounce();
    test_long_press();
    test_tie();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
